// File: rtl/det_event_counter_pkg.sv
// Shared types and defaults for the detection-event window counter.
// Holds the FSM state encoding and the default window length and count width.
// Imported by the interface, the window timer and the top.
package det_cnt_pkg;

    localparam int DEF_WIN_LEN = 16;
    localparam int DEF_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        COUNT  = 2'b01,
        REPORT = 2'b10
    } state_t;

endpackage

// File: rtl/det_event_counter_if.sv
// Bundle of the detector input, window control and result handshake signals.
// master: the counter (drives busy/cnt_out/cnt_valid/ovf); slave: its environment.
// Result handshake is valid/ready on cnt_valid/cnt_ready.
interface det_cnt_if
    import det_cnt_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             det_in;
    logic             start;
    logic             busy;
    logic [CNT_W-1:0] cnt_out;
    logic             cnt_valid;
    logic             cnt_ready;
    logic             ovf;

    modport master (
        input  det_in, start, cnt_ready,
        output busy, cnt_out, cnt_valid, ovf
    );

    modport slave (
        output det_in, start, cnt_ready,
        input  busy, cnt_out, cnt_valid, ovf
    );
endinterface

// File: rtl/det_event_counter_win_timer.sv
// Window timer: counts COUNT cycles and flags the last sample of a window.
// Latency: last is combinational from the registered timer value.
// No backpressure; load wins over enable, and the timer parks at WIN_LEN-1.
// Ports: clk, rst (async active-low), load (clear to 0), enable (advance), last.
module det_win_timer
    import det_cnt_pkg::*;
#(
    parameter int WIN_LEN = DEF_WIN_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic last
);
    localparam int TW = $clog2(WIN_LEN);
    localparam logic [TW-1:0] LAST_VAL = TW'(WIN_LEN - 1);

    logic [TW-1:0] tmr;

    assign last = (tmr == LAST_VAL);

    // Holding at LAST_VAL instead of incrementing keeps the timer from
    // wrapping when WIN_LEN is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr <= '0;
        end else if (load) begin
            tmr <= '0;
        end else if (enable && !last) begin
            tmr <= tmr + 1'b1;
        end
    end
endmodule

// File: rtl/det_event_counter.sv
// Counts detector pulses over a WIN_LEN-cycle window and reports a saturating count.
// Latency: cnt_valid rises 1 cycle after the last sample of the window.
// Backpressure: result held in REPORT until cnt_ready; det_in pulses outside COUNT are dropped.
// Ports: clk, rst (async active-low), bus (det_cnt_if.master).
// Optional macro DET_COUNT_AUTO_RESTART_EN: windows run back-to-back without start.
module det_event_counter
    import det_cnt_pkg::*;
#(
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic      clk,
    input  logic      rst,
    det_cnt_if.master bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             ovf_acc;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             win_last;
    logic             win_load;
    logic             handshake;
    logic             go_idle;
    logic             go_rpt;

    logic             busy_r;
    logic [CNT_W-1:0] cnt_out_r;
    logic             cnt_valid_r;
    logic             ovf_r;

`ifdef DET_COUNT_AUTO_RESTART_EN
    // Free-running: leave IDLE once after reset and restart on every handshake.
    assign go_idle = 1'b1;
    assign go_rpt  = 1'b1;
`else
    assign go_idle = bus.start;
    assign go_rpt  = bus.start;
`endif

    assign handshake = (state == REPORT) && cnt_valid_r && bus.cnt_ready;
    assign win_load  = ((state == IDLE) && go_idle) || (handshake && go_rpt);

    det_win_timer #(.WIN_LEN(WIN_LEN)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (win_load),
        .enable (state == COUNT),
        .last   (win_last)
    );

    // Saturating increment; a pulse that finds the count already full marks overflow.
    always_comb begin
        cnt_nxt = count;
        ovf_nxt = ovf_acc;
        if (bus.det_in) begin
            if (count == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= '0;
            ovf_acc     <= 1'b0;
            busy_r      <= 1'b0;
            cnt_out_r   <= '0;
            cnt_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go_idle) begin
                        state   <= COUNT;
                        count   <= '0;
                        ovf_acc <= 1'b0;
                        ovf_r   <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end
                COUNT: begin
                    count   <= cnt_nxt;
                    ovf_acc <= ovf_nxt;
                    // The last sample is folded straight into the reported result.
                    if (win_last) begin
                        state       <= REPORT;
                        busy_r      <= 1'b0;
                        cnt_valid_r <= 1'b1;
                        cnt_out_r   <= cnt_nxt;
                        ovf_r       <= ovf_nxt;
                    end
                end
                REPORT: begin
                    if (handshake) begin
                        cnt_valid_r <= 1'b0;
                        cnt_out_r   <= '0;
                        if (go_rpt) begin
                            state   <= COUNT;
                            count   <= '0;
                            ovf_acc <= 1'b0;
                            ovf_r   <= 1'b0;
                            busy_r  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.cnt_out   = cnt_out_r;
    assign bus.cnt_valid = cnt_valid_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_det_event_counter.sv
// Directed bench for det_event_counter (WIN_LEN=16, CNT_W=4).
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Build with DET_COUNT_AUTO_RESTART_EN to exercise the free-running mode instead.
module tb_det_event_counter;
    import det_cnt_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    det_cnt_if #(.CNT_W(4)) bus ();

    det_event_counter #(.WIN_LEN(16), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Optionally pulse start, then drive one window; mask bit c-1 is det_in on window cycle c.
    task automatic run_window(input bit do_start, input logic [15:0] mask);
        if (do_start) begin
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
        end
        for (int c = 1; c <= 16; c++) begin
            bus.det_in = mask[c-1];
            step();
        end
        bus.det_in = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.det_in = 1'b0;
        bus.start = 1'b0;
        bus.cnt_ready = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({bus.busy, bus.cnt_valid, bus.ovf, bus.cnt_out} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b valid=%b ovf=%b cnt=%0d, required all 0",
                     bus.busy, bus.cnt_valid, bus.ovf, bus.cnt_out);
        end
`ifndef DET_COUNT_AUTO_RESTART_EN
        rst = 1'b1;
        bus.det_in = 1'b1;
        repeat (4) step();
        bus.det_in = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.cnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_without_start: busy=%b valid=%b, required 0 0", bus.busy, bus.cnt_valid);
        end
`endif
    endtask

`ifndef DET_COUNT_AUTO_RESTART_EN
    task automatic test_basic_count;
        logic [15:0] mask;
        mask = 16'b1000_0000_0100_0100; // cycles 3, 7, 16
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %b, required 1", bus.busy);
        end
        for (int c = 1; c <= 16; c++) begin
            bus.det_in = mask[c-1];
            step();
            if (c == 15) begin
                n_checks++;
                if (bus.cnt_valid !== 1'b0 || bus.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL window_cycle15: valid=%b busy=%b, required 0 1", bus.cnt_valid, bus.busy);
                end
            end
        end
        bus.det_in = 1'b0;
        n_checks++;
        if (bus.cnt_valid !== 1'b1 || bus.cnt_out !== 4'd3 || bus.ovf !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: valid=%b cnt=%0d ovf=%b busy=%b, required 1 3 0 0",
                     bus.cnt_valid, bus.cnt_out, bus.ovf, bus.busy);
        end
        bus.cnt_ready = 1'b1;
        step();
        bus.cnt_ready = 1'b0;
        n_checks++;
        if (bus.cnt_valid !== 1'b0 || bus.cnt_out !== 4'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after_handshake: valid=%b cnt=%0d busy=%b, required 0 0 0",
                     bus.cnt_valid, bus.cnt_out, bus.busy);
        end
    endtask

    task automatic test_saturate;
        run_window(1'b1, 16'hFFFF);
        n_checks++;
        if (bus.cnt_out !== 4'd15 || bus.ovf !== 1'b1 || bus.cnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate_16: cnt=%0d ovf=%b valid=%b, required 15 1 1",
                     bus.cnt_out, bus.ovf, bus.cnt_valid);
        end
        bus.cnt_ready = 1'b1;
        step();
        bus.cnt_ready = 1'b0;
        // Exactly 15 pulses reaches the ceiling without overflowing.
        run_window(1'b1, 16'h7FFF);
        n_checks++;
        if (bus.cnt_out !== 4'd15 || bus.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL saturate_15: cnt=%0d ovf=%b, required 15 0", bus.cnt_out, bus.ovf);
        end
        bus.cnt_ready = 1'b1;
        step();
        bus.cnt_ready = 1'b0;
    endtask

    task automatic test_report_hold;
        run_window(1'b1, 16'h0012); // cycles 2 and 5
        for (int i = 0; i < 5; i++) begin
            bus.det_in = i[0];
            bus.start = ~i[0];
            step();
            n_checks++;
            if (bus.cnt_out !== 4'd2 || bus.cnt_valid !== 1'b1 || bus.busy !== 1'b0 || bus.ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL report_hold[%0d]: cnt=%0d valid=%b busy=%b ovf=%b, required 2 1 0 0",
                         i, bus.cnt_out, bus.cnt_valid, bus.busy, bus.ovf);
            end
        end
        bus.det_in = 1'b0;
        bus.start = 1'b0;
        bus.cnt_ready = 1'b1;
        step();
        bus.cnt_ready = 1'b0;
        step();
        n_checks++;
        if (bus.cnt_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cnt_out !== 4'd0) begin
            n_fail++;
            $display("FAIL report_release: valid=%b busy=%b cnt=%0d, required 0 0 0",
                     bus.cnt_valid, bus.busy, bus.cnt_out);
        end
    endtask

    task automatic test_back_to_back;
        run_window(1'b1, 16'h0111); // 3 pulses
        n_checks++;
        if (bus.cnt_out !== 4'd3) begin
            n_fail++;
            $display("FAIL b2b_first: cnt=%0d, required 3", bus.cnt_out);
        end
        bus.cnt_ready = 1'b1;
        bus.start = 1'b1;
        step();
        bus.cnt_ready = 1'b0;
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.cnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: busy=%b valid=%b, required 1 0", bus.busy, bus.cnt_valid);
        end
        run_window(1'b0, 16'h0400); // 1 pulse
        n_checks++;
        if (bus.cnt_out !== 4'd1 || bus.cnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: cnt=%0d valid=%b, required 1 1", bus.cnt_out, bus.cnt_valid);
        end
        bus.cnt_ready = 1'b1;
        step();
        bus.cnt_ready = 1'b0;
    endtask

    task automatic test_reset_mid_window;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            bus.det_in = (c == 2 || c == 5 || c == 8);
            step();
        end
        bus.det_in = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.cnt_valid, bus.ovf, bus.cnt_out} !== 7'd0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b valid=%b ovf=%b cnt=%0d, required all 0",
                     bus.busy, bus.cnt_valid, bus.ovf, bus.cnt_out);
        end
        step();
        rst = 1'b1;
        repeat (20) step();
        bus.det_in = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.cnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_report: busy=%b valid=%b, required 0 0", bus.busy, bus.cnt_valid);
        end
        run_window(1'b1, 16'h0008); // 1 pulse
        n_checks++;
        if (bus.cnt_out !== 4'd1 || bus.cnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fresh_after_reset: cnt=%0d valid=%b, required 1 1", bus.cnt_out, bus.cnt_valid);
        end
        bus.cnt_ready = 1'b1;
        step();
        bus.cnt_ready = 1'b0;
    endtask
`else
    task automatic test_auto_restart;
        bus.cnt_ready = 1'b1;
        bus.det_in = 1'b1;
        rst = 1'b1;
        // Edge k after release: k%17 in 0..15 counting, 16 reporting.
        for (int k = 0; k < 51; k++) begin
            step();
            n_checks++;
            if ((k % 17) == 16) begin
                if (bus.cnt_valid !== 1'b1 || bus.busy !== 1'b0 || bus.cnt_out !== 4'd15 || bus.ovf !== 1'b1) begin
                    n_fail++;
                    $display("FAIL auto_report[%0d]: valid=%b busy=%b cnt=%0d ovf=%b, required 1 0 15 1",
                             k, bus.cnt_valid, bus.busy, bus.cnt_out, bus.ovf);
                end
            end else begin
                if (bus.busy !== 1'b1 || bus.cnt_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL auto_count[%0d]: busy=%b valid=%b, required 1 0",
                             k, bus.busy, bus.cnt_valid);
                end
            end
        end
        bus.det_in = 1'b0;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
`ifndef DET_COUNT_AUTO_RESTART_EN
        test_basic_count();
        test_saturate();
        test_report_hold();
        test_back_to_back();
        test_reset_mid_window();
`else
        test_auto_restart();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/det_event_counter.md
DET_EVENT_COUNTER -- requirements
Module: det_event_counter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter WIN_LEN, default 16, SHALL set the number of det_in samples per window (legal range 2..65535).
REQ-003 Parameter CNT_W, default 4, SHALL set the width of the detection count.
REQ-004 Port clk, input, 1, SHALL be the rising-edge clock.
REQ-005 Port rst, input, 1, SHALL be the asynchronous active-low reset.
REQ-006 Port det_in, input, 1, SHALL carry the one-cycle detect pulse from the upstream 11101 sequence detector.
REQ-007 Port start, input, 1, SHALL request a new counting window.
REQ-008 Port busy, output, 1, SHALL be high while a window is counting.
REQ-009 Port cnt_out, output, CNT_W, SHALL hold the count of the completed window.
REQ-010 Port cnt_valid, output, 1, SHALL flag cnt_out as valid.
REQ-011 Port cnt_ready, input, 1, SHALL be the downstream acceptance signal.
REQ-012 Port ovf, output, 1, SHALL flag saturation of the reported window's count.

Function
REQ-013 The block SHALL implement the FSM states IDLE, COUNT and REPORT.
REQ-014 IDLE SHALL move to COUNT on the clock edge where start=1, clearing the count, ovf and the window timer.
REQ-015 COUNT SHALL last exactly WIN_LEN cycles and sample det_in once per cycle.
REQ-016 Each sampled det_in=1 SHALL add 1 to the count.
REQ-017 The count SHALL saturate at 2^CNT_W-1, and a det_in=1 sampled at saturation SHALL set ovf.
REQ-018 On the last COUNT cycle, the FSM SHALL move to REPORT.
REQ-019 cnt_valid SHALL rise in the first cycle after the last sample, giving a latency of 1 cycle.
REQ-020 In REPORT, cnt_out, ovf and cnt_valid SHALL hold stable until the cycle where cnt_valid and cnt_ready are both high.
REQ-021 On that handshake cycle, the FSM SHALL go to IDLE and cnt_valid SHALL drop on the next cycle.
REQ-022 If start=1 in the handshake cycle, the FSM SHALL go directly to COUNT.
REQ-023 start SHALL be ignored while in COUNT, and in REPORT outside the handshake cycle.
REQ-024 det_in SHALL be ignored outside COUNT, so those pulses are lost.
REQ-025 A det_in pulse on the last COUNT cycle SHALL be included in the count.
REQ-026 busy SHALL equal (state==COUNT).
REQ-027 cnt_out SHALL read 0 whenever cnt_valid is low.
REQ-028 The window timer SHALL be ceil(log2(WIN_LEN)) bits wide and SHALL never wrap within a window.

Reset
REQ-029 While rst=0, the block SHALL immediately force state=IDLE, count=0, timer=0, cnt_out=0, cnt_valid=0, busy=0, ovf=0.
REQ-030 A reset asserted mid-COUNT or mid-REPORT SHALL discard the partial or pending result with no report.
REQ-031 After reset release, the block SHALL need a start before counting.

Configuration
REQ-032 With macro DET_COUNT_AUTO_RESTART_EN defined, the FSM SHALL go IDLE->COUNT once after reset without start, and go REPORT->COUNT on every handshake, giving back-to-back windows.
REQ-033 In that mode, the block SHALL ignore start.
REQ-034 Without DET_COUNT_AUTO_RESTART_EN, windows SHALL begin only on start, per REQ-014/REQ-022.

Structure
REQ-035 Package det_cnt_pkg SHALL hold the state encoding (IDLE=2'b00, COUNT=2'b01, REPORT=2'b10) and default WIN_LEN/CNT_W constants.
REQ-036 Sub-module det_win_timer (load, enable, last-cycle flag) SHALL implement the window timer.
REQ-037 The top SHALL hold the FSM, the saturating counter and the output register.

Verification
REQ-038 Reset; start; drive WIN_LEN=16 cycles with det_in high on cycles 3, 7 and 16 -> cnt_valid rises 1 cycle after the window, cnt_out=3, ovf=0.
REQ-039 With CNT_W=4, det_in held high for all 16 window cycles -> cnt_out=15, ovf=1.
REQ-040 In REPORT, hold cnt_ready=0 for 5 cycles while toggling det_in and start -> cnt_out stable, no new window; then cnt_ready=1 -> IDLE next cycle.
REQ-041 Handshake with start=1 in the same cycle -> busy=1 next cycle; the new window counts from 0.
REQ-042 Assert rst=0 at window cycle 8 with det pulses present -> all outputs 0 asynchronously; after release and start, a fresh count excludes the earlier pulses.
REQ-043 With DET_COUNT_AUTO_RESTART_EN and cnt_ready tied to 1 -> consecutive windows of exactly 16 COUNT cycles plus 1 REPORT cycle each, with no start needed.
